// File: rtl/ikbd_serial_bridge.sv
// Bridges the ACIA byte interface to the keyboard's 8N1 serial link.
// A 16x oversampled receiver runs alongside a transmitter that acknowledges each queued byte.
module ikbd_serial_bridge #(
    parameter int CLK_DIV = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       acia_tx_available,
    input  logic [7:0] acia_tx_data,
    output logic       acia_tx_strobe,
    output logic       acia_rx_strobe,
    output logic [7:0] acia_rx_data,
    output logic       ikbd_txd,
    input  logic       ikbd_rxd,
    output logic       frame_err,
    output logic       tx_busy
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_ACK, TX_SHIFT} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Free-running oversample prescaler used by the receiver
    logic [DIV_W-1:0] presc_reg;
    logic             tick;

    assign tick = (presc_reg == DIV_MAX);

    always_ff @(posedge clk) begin
        if (reset || tick) presc_reg <= '0;
        else               presc_reg <= presc_reg + 1'b1;
    end

    // Transmitter: the bit-phase divider restarts at each start bit, so
    // every transmitted bit is exactly 16*CLK_DIV clocks long.
    tx_state_t        tx_state_reg, tx_state_next;
    logic [9:0]       frame_reg, frame_next;
    logic [1:0]       ack_cnt_reg, ack_cnt_next;
    logic [DIV_W-1:0] tx_div_reg, tx_div_next;
    logic [3:0]       tx_tick_reg, tx_tick_next;
    logic [3:0]       tx_bit_reg, tx_bit_next;
    logic             txd_reg;

    always_comb begin
        tx_state_next = tx_state_reg;
        frame_next    = frame_reg;
        ack_cnt_next  = ack_cnt_reg;
        tx_div_next   = tx_div_reg;
        tx_tick_next  = tx_tick_reg;
        tx_bit_next   = tx_bit_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                if (acia_tx_available) begin
                    frame_next    = {1'b1, acia_tx_data, 1'b0};
                    ack_cnt_next  = '0;
                    tx_state_next = TX_ACK;
                end
            end
            TX_ACK: begin
                if (ack_cnt_reg == 2'd3) begin
                    tx_state_next = TX_SHIFT;
                    tx_div_next   = '0;
                    tx_tick_next  = '0;
                    tx_bit_next   = '0;
                end else begin
                    ack_cnt_next = ack_cnt_reg + 2'd1;
                end
            end
            TX_SHIFT: begin
                if (tx_div_reg == DIV_MAX) begin
                    tx_div_next  = '0;
                    tx_tick_next = tx_tick_reg + 4'd1;
                    if (tx_tick_reg == 4'd15) begin
                        if (tx_bit_reg == 4'd9) begin
                            // Chain straight into the next ACK so the inter-frame gap is only the ACK
                            if (acia_tx_available) begin
                                frame_next    = {1'b1, acia_tx_data, 1'b0};
                                ack_cnt_next  = '0;
                                tx_state_next = TX_ACK;
                            end else begin
                                tx_state_next = TX_IDLE;
                            end
                        end else begin
                            tx_bit_next = tx_bit_reg + 4'd1;
                            frame_next  = {1'b1, frame_reg[9:1]};
                        end
                    end
                end else begin
                    tx_div_next = tx_div_reg + 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            frame_reg    <= '1;
            ack_cnt_reg  <= '0;
            tx_div_reg   <= '0;
            tx_tick_reg  <= '0;
            tx_bit_reg   <= '0;
            txd_reg      <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            frame_reg    <= frame_next;
            ack_cnt_reg  <= ack_cnt_next;
            tx_div_reg   <= tx_div_next;
            tx_tick_reg  <= tx_tick_next;
            tx_bit_reg   <= tx_bit_next;
            txd_reg      <= (tx_state_next == TX_SHIFT) ? frame_next[0] : 1'b1;
        end
    end

    assign ikbd_txd       = txd_reg;
    assign acia_tx_strobe = (tx_state_reg == TX_ACK);
    assign tx_busy        = (tx_state_reg != TX_IDLE);

    // Receiver
    logic       rx_meta_reg, rxs_reg;
    rx_state_t  rx_state_reg, rx_state_next;
    logic [3:0] rx_tick_reg, rx_tick_next;
    logic [2:0] rx_bit_reg, rx_bit_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic [7:0] rx_data_reg, rx_data_next;
    logic [2:0] rx_strb_cnt_reg, rx_strb_cnt_next;
    logic       frame_err_reg, frame_err_next;
    logic       rx_wait_high_reg, rx_wait_high_next;

    always_comb begin
        rx_state_next     = rx_state_reg;
        rx_tick_next      = rx_tick_reg;
        rx_bit_next       = rx_bit_reg;
        rx_shift_next     = rx_shift_reg;
        rx_data_next      = rx_data_reg;
        rx_strb_cnt_next  = (rx_strb_cnt_reg != 3'd0) ? rx_strb_cnt_reg - 3'd1 : 3'd0;
        frame_err_next    = 1'b0;
        rx_wait_high_next = rx_wait_high_reg;
        case (rx_state_reg)
            RX_IDLE: begin
                // After a framing error the line must return high before a new start edge counts
                if (rx_wait_high_reg) begin
                    if (rxs_reg) rx_wait_high_next = 1'b0;
                end else if (tick && !rxs_reg) begin
                    rx_state_next = RX_START;
                    rx_tick_next  = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_tick_reg == 4'd7) begin
                        if (!rxs_reg) begin
                            rx_state_next = RX_DATA;
                            rx_tick_next  = '0;
                            rx_bit_next   = '0;
                        end else begin
                            rx_state_next = RX_IDLE;
                        end
                    end else begin
                        rx_tick_next = rx_tick_reg + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    rx_tick_next = rx_tick_reg + 4'd1;
                    if (rx_tick_reg == 4'd15) begin
                        rx_shift_next = {rxs_reg, rx_shift_reg[7:1]};
                        if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
                        else                    rx_bit_next   = rx_bit_reg + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    rx_tick_next = rx_tick_reg + 4'd1;
                    if (rx_tick_reg == 4'd15) begin
                        if (rxs_reg) begin
                            rx_data_next     = rx_shift_reg;
                            rx_strb_cnt_next = 3'd4;
                        end else begin
                            frame_err_next    = 1'b1;
                            rx_wait_high_next = 1'b1;
                        end
                        rx_state_next = RX_IDLE;
                    end
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg      <= 1'b1;
            rxs_reg          <= 1'b1;
            rx_state_reg     <= RX_IDLE;
            rx_tick_reg      <= '0;
            rx_bit_reg       <= '0;
            rx_shift_reg     <= '0;
            rx_data_reg      <= 8'h00;
            rx_strb_cnt_reg  <= '0;
            frame_err_reg    <= 1'b0;
            rx_wait_high_reg <= 1'b0;
        end else begin
            rx_meta_reg      <= ikbd_rxd;
            rxs_reg          <= rx_meta_reg;
            rx_state_reg     <= rx_state_next;
            rx_tick_reg      <= rx_tick_next;
            rx_bit_reg       <= rx_bit_next;
            rx_shift_reg     <= rx_shift_next;
            rx_data_reg      <= rx_data_next;
            rx_strb_cnt_reg  <= rx_strb_cnt_next;
            frame_err_reg    <= frame_err_next;
            rx_wait_high_reg <= rx_wait_high_next;
        end
    end

    assign acia_rx_data   = rx_data_reg;
    assign acia_rx_strobe = (rx_strb_cnt_reg != 3'd0);
    assign frame_err      = frame_err_reg;

endmodule

// File: tb/tb_ikbd_serial_bridge.sv
// Directed bench for ikbd_serial_bridge: TX framing/ACK, RX reception, glitch, framing error,
// full-duplex back-to-back traffic and mid-frame reset.
module tb_ikbd_serial_bridge;
    localparam int BIT_CLK = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       acia_tx_available = 1'b0;
    logic [7:0] acia_tx_data = 8'h00;
    logic       acia_tx_strobe;
    logic       acia_rx_strobe;
    logic [7:0] acia_rx_data;
    logic       ikbd_txd;
    logic       ikbd_rxd = 1'b1;
    logic       frame_err;
    logic       tx_busy;

    int tests = 0;
    int fails = 0;

    int   cyc = 0;
    int   rx_rises = 0;
    int   rx_high = 0;
    int   fe_cycles = 0;
    int   tx_run = 0, tx_max = 0, rx_run = 0, rx_max = 0;
    logic rx_strobe_prev = 1'b0;

    ikbd_serial_bridge dut (
        .clk              (clk),
        .reset            (reset),
        .acia_tx_available(acia_tx_available),
        .acia_tx_data     (acia_tx_data),
        .acia_tx_strobe   (acia_tx_strobe),
        .acia_rx_strobe   (acia_rx_strobe),
        .acia_rx_data     (acia_rx_data),
        .ikbd_txd         (ikbd_txd),
        .ikbd_rxd         (ikbd_rxd),
        .frame_err        (frame_err),
        .tx_busy          (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled away from the active edge
    always @(negedge clk) begin
        rx_strobe_prev <= acia_rx_strobe;
        if (acia_rx_strobe && !rx_strobe_prev) rx_rises <= rx_rises + 1;
        if (acia_rx_strobe) rx_high <= rx_high + 1;
        if (frame_err) fe_cycles <= fe_cycles + 1;
        tx_run <= acia_tx_strobe ? tx_run + 1 : 0;
        rx_run <= acia_rx_strobe ? rx_run + 1 : 0;
        if (acia_tx_strobe && tx_run + 1 > tx_max) tx_max <= tx_run + 1;
        if (acia_rx_strobe && rx_run + 1 > rx_max) rx_max <= rx_run + 1;
    end

    task automatic drive_rx(input logic [7:0] d, input logic stop_bit);
        ikbd_rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ikbd_rxd = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        ikbd_rxd = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
        ikbd_rxd = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        tests++; if (ikbd_txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b expected 1", ikbd_txd); end
        tests++; if (acia_tx_strobe !== 1'b0) begin fails++; $display("FAIL reset_tx_strobe: got %b expected 0", acia_tx_strobe); end
        tests++; if (acia_rx_strobe !== 1'b0) begin fails++; $display("FAIL reset_rx_strobe: got %b expected 0", acia_rx_strobe); end
        tests++; if (acia_rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", acia_rx_data); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic test_tx_a5;
        logic [9:0] fr;
        int n, hi;
        fr = {1'b1, 8'hA5, 1'b0};
        acia_tx_data = 8'hA5;
        acia_tx_available = 1'b1;
        n = 0;
        while (!acia_tx_strobe && n < 100) begin @(negedge clk); n++; end
        tests++; if (acia_tx_strobe !== 1'b1) begin fails++; $display("FAIL tx_ack_seen: got %b expected 1", acia_tx_strobe); end
        tests++; if (ikbd_txd !== 1'b1 || tx_busy !== 1'b1) begin fails++; $display("FAIL tx_ack_line: txd %b busy %b expected 1 1", ikbd_txd, tx_busy); end
        acia_tx_available = 1'b0;
        acia_tx_data = 8'hFF;
        hi = 0;
        while (acia_tx_strobe && hi < 20) begin @(negedge clk); hi++; end
        tests++; if (hi != 4) begin fails++; $display("FAIL tx_ack_len: got %0d expected 4", hi); end
        for (int b = 0; b < 10; b++) begin
            tests++; if (ikbd_txd !== fr[b]) begin fails++; $display("FAIL tx_bit%0d_first: got %b expected %b", b, ikbd_txd, fr[b]); end
            repeat (BIT_CLK - 1) @(negedge clk);
            tests++; if (ikbd_txd !== fr[b]) begin fails++; $display("FAIL tx_bit%0d_last: got %b expected %b", b, ikbd_txd, fr[b]); end
            @(negedge clk);
        end
        tests++; if (tx_busy !== 1'b0 || ikbd_txd !== 1'b1) begin fails++; $display("FAIL tx_done: busy %b txd %b expected 0 1", tx_busy, ikbd_txd); end
        $display("[TB] tx A5 frame checked");
    endtask

    task automatic test_rx_3c;
        int n, hi, r0, f0;
        r0 = rx_rises; f0 = fe_cycles; n = 0; hi = 0;
        fork
            drive_rx(8'h3C, 1'b1);
            begin
                while (!acia_rx_strobe && n < 12000) begin @(negedge clk); n++; end
                while (acia_rx_strobe && hi < 20) begin @(negedge clk); hi++; end
            end
        join
        tests++; if (n < 9700 || n > 9850) begin fails++; $display("FAIL rx_latency: got %0d expected 9700..9850", n); end
        tests++; if (hi != 4) begin fails++; $display("FAIL rx_strobe_len: got %0d expected 4", hi); end
        tests++; if (acia_rx_data !== 8'h3C) begin fails++; $display("FAIL rx_data_3c: got %h expected 3c", acia_rx_data); end
        tests++; if (rx_rises - r0 != 1) begin fails++; $display("FAIL rx_strobe_count: got %0d expected 1", rx_rises - r0); end
        tests++; if (fe_cycles != f0) begin fails++; $display("FAIL rx_no_ferr: got %0d expected 0", fe_cycles - f0); end
        $display("[TB] rx 3C frame latency %0d", n);
    endtask

    task automatic test_glitch;
        int r0, f0;
        r0 = rx_rises; f0 = fe_cycles;
        ikbd_rxd = 1'b0;
        repeat (300) @(negedge clk);
        ikbd_rxd = 1'b1;
        repeat (1500) @(negedge clk);
        tests++; if (rx_rises != r0) begin fails++; $display("FAIL glitch_strobe: got %0d expected 0", rx_rises - r0); end
        tests++; if (fe_cycles != f0) begin fails++; $display("FAIL glitch_ferr: got %0d expected 0", fe_cycles - f0); end
        tests++; if (acia_rx_data !== 8'h3C) begin fails++; $display("FAIL glitch_data: got %h expected 3c", acia_rx_data); end
        $display("[TB] glitch rejected");
    endtask

    task automatic test_frame_err;
        int r0, f0;
        r0 = rx_rises; f0 = fe_cycles;
        drive_rx(8'hFF, 1'b0);
        repeat (100) @(negedge clk);
        tests++; if (fe_cycles - f0 != 1) begin fails++; $display("FAIL ferr_pulse: got %0d cycles expected 1", fe_cycles - f0); end
        tests++; if (rx_rises != r0) begin fails++; $display("FAIL ferr_no_strobe: got %0d expected 0", rx_rises - r0); end
        tests++; if (acia_rx_data !== 8'h3C) begin fails++; $display("FAIL ferr_data_held: got %h expected 3c", acia_rx_data); end
        drive_rx(8'h12, 1'b1);
        repeat (100) @(negedge clk);
        tests++; if (acia_rx_data !== 8'h12) begin fails++; $display("FAIL ferr_next_data: got %h expected 12", acia_rx_data); end
        tests++; if (rx_rises - r0 != 1) begin fails++; $display("FAIL ferr_next_strobe: got %0d expected 1", rx_rises - r0); end
        tests++; if (fe_cycles - f0 != 1) begin fails++; $display("FAIL ferr_next_clean: got %0d expected 1", fe_cycles - f0); end
        $display("[TB] framing error and recovery checked");
    endtask

    task automatic test_back_to_back;
        logic [7:0] qd [3];
        logic [9:0] fr;
        int r0, h0, n, hi, prev_start;
        qd[0] = 8'h01; qd[1] = 8'h02; qd[2] = 8'h03;
        r0 = rx_rises; h0 = rx_high; prev_start = 0;
        acia_tx_data = qd[0];
        acia_tx_available = 1'b1;
        fork
            drive_rx(8'h55, 1'b1);
            begin
                for (int f = 0; f < 3; f++) begin
                    fr = {1'b1, qd[f], 1'b0};
                    n = 0;
                    while (!acia_tx_strobe && n < 100) begin @(negedge clk); n++; end
                    tests++; if (acia_tx_strobe !== 1'b1) begin fails++; $display("FAIL b2b_ack%0d_seen: got %b expected 1", f, acia_tx_strobe); end
                    if (f < 2) acia_tx_data = qd[f + 1];
                    else       acia_tx_available = 1'b0;
                    hi = 0;
                    while (acia_tx_strobe && hi < 20) begin @(negedge clk); hi++; end
                    tests++; if (hi != 4) begin fails++; $display("FAIL b2b_ack%0d_len: got %0d expected 4", f, hi); end
                    if (f > 0) begin
                        tests++; if (cyc - prev_start != 10 * BIT_CLK + 4) begin fails++; $display("FAIL b2b_gap%0d: got %0d expected %0d", f, cyc - prev_start, 10 * BIT_CLK + 4); end
                    end
                    prev_start = cyc;
                    for (int b = 0; b < 10; b++) begin
                        repeat (BIT_CLK / 2) @(negedge clk);
                        tests++; if (ikbd_txd !== fr[b]) begin fails++; $display("FAIL b2b_f%0d_bit%0d: got %b expected %b", f, b, ikbd_txd, fr[b]); end
                        repeat (BIT_CLK / 2) @(negedge clk);
                    end
                end
            end
        join
        repeat (10) @(negedge clk);
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b expected 0", tx_busy); end
        tests++; if (acia_rx_data !== 8'h55) begin fails++; $display("FAIL b2b_rx_data: got %h expected 55", acia_rx_data); end
        tests++; if (rx_rises - r0 != 1) begin fails++; $display("FAIL b2b_rx_strobes: got %0d expected 1", rx_rises - r0); end
        tests++; if (rx_high - h0 != 4) begin fails++; $display("FAIL b2b_rx_strobe_len: got %0d expected 4", rx_high - h0); end
        $display("[TB] back-to-back 01 02 03 with rx 55 checked");
    endtask

    task automatic test_reset_mid;
        int n, r0, f0;
        r0 = rx_rises; f0 = fe_cycles;
        ikbd_rxd = 1'b0;
        repeat (2 * BIT_CLK) @(negedge clk);
        acia_tx_data = 8'h00;
        acia_tx_available = 1'b1;
        n = 0;
        while (!acia_tx_strobe && n < 100) begin @(negedge clk); n++; end
        acia_tx_available = 1'b0;
        n = 0;
        while (acia_tx_strobe && n < 20) begin @(negedge clk); n++; end
        repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
        tests++; if (ikbd_txd !== 1'b0 || tx_busy !== 1'b1) begin fails++; $display("FAIL mid_pre: txd %b busy %b expected 0 1", ikbd_txd, tx_busy); end
        reset = 1'b1;
        ikbd_rxd = 1'b1;
        @(negedge clk);
        tests++; if (ikbd_txd !== 1'b1) begin fails++; $display("FAIL mid_txd: got %b expected 1", ikbd_txd); end
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b expected 0", tx_busy); end
        tests++; if (acia_tx_strobe !== 1'b0 || acia_rx_strobe !== 1'b0) begin fails++; $display("FAIL mid_strobes: tx %b rx %b expected 0 0", acia_tx_strobe, acia_rx_strobe); end
        tests++; if (acia_rx_data !== 8'h00) begin fails++; $display("FAIL mid_rx_data: got %h expected 00", acia_rx_data); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL mid_ferr: got %b expected 0", frame_err); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4000) @(negedge clk);
        tests++; if (rx_rises != r0) begin fails++; $display("FAIL mid_no_rx_strobe: got %0d expected 0", rx_rises - r0); end
        tests++; if (fe_cycles != f0) begin fails++; $display("FAIL mid_no_ferr: got %0d expected 0", fe_cycles - f0); end
        tests++; if (ikbd_txd !== 1'b1 || tx_busy !== 1'b0) begin fails++; $display("FAIL mid_after: txd %b busy %b expected 1 0", ikbd_txd, tx_busy); end
        $display("[TB] mid-frame reset checked");
    endtask

    task automatic test_strobe_limits;
        tests++; if (tx_max != 4) begin fails++; $display("FAIL tx_strobe_max: got %0d expected 4", tx_max); end
        tests++; if (rx_max != 4) begin fails++; $display("FAIL rx_strobe_max: got %0d expected 4", rx_max); end
        $display("[TB] strobe widths checked");
    endtask

    initial begin
        test_reset;
        test_tx_a5;
        test_rx_3c;
        test_glitch;
        test_frame_err;
        test_back_to_back;
        test_reset_mid;
        test_strobe_limits;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ikbd_serial_bridge.md
IKBD_SERIAL_BRIDGE -- requirements
Module: ikbd_serial_bridge

Interface
REQ-001 Parameter CLK_DIV, default 64, clk cycles per oversample tick; 16 ticks per bit, giving 1024 clk per bit (7812.5 bit/s at 8 MHz).
REQ-002 clk  in  1  system clock (8 MHz); all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 acia_tx_available  in  1  ACIA has a byte queued for the keyboard.
REQ-005 acia_tx_data  in  8  byte at the head of the ACIA output queue.
REQ-006 acia_tx_strobe  out  1  acknowledge pulse; the ACIA pops its queue on the rising edge.
REQ-007 acia_rx_strobe  out  1  pulse; the ACIA pushes acia_rx_data on the rising edge.
REQ-008 acia_rx_data  out  8  byte received from the keyboard.
REQ-009 ikbd_txd  out  1  serial line to the keyboard, 8N1, LSB first, idle high.
REQ-010 ikbd_rxd  in  1  asynchronous serial line from the keyboard.
REQ-011 frame_err  out  1  one-clk pulse when a received stop bit reads 0.
REQ-012 tx_busy  out  1  high while the transmitter is not IDLE.

Function
REQ-013 Prescaler counts 0..CLK_DIV-1 and wraps; tick is high for one clk when count = CLK_DIV-1.
REQ-014 TX FSM states: IDLE, ACK, SHIFT.
REQ-015 IDLE with acia_tx_available=1: latch acia_tx_data into a 10-bit frame {1, data, 0}, raise acia_tx_strobe, and enter ACK.
REQ-016 ACK lasts exactly 4 clk with acia_tx_strobe=1; on exit the strobe drops to 0 and the FSM enters SHIFT.
REQ-017 acia_tx_data is sampled only on the IDLE->ACK transition; later changes do not affect the frame in flight.
REQ-018 SHIFT: ikbd_txd drives frame bit 0 (start) first; each bit lasts 16 ticks; 10 bits are sent LSB first; then return to IDLE.
REQ-019 The first TX bit begins on the clk after ACK exits; the bit counter is 4 bits, 0..9; the tick counter is 4 bits and wraps 15->0 to advance.
REQ-020 ikbd_txd = 1 in IDLE and ACK.
REQ-021 Back-to-back bytes: if acia_tx_available=1 in IDLE right after a stop bit, the next ACK starts immediately. Minimum gap between stop bit end and next start bit is 4 clk (the ACK period).
REQ-022 ikbd_rxd passes through a 2-flop synchroniser; the RX FSM uses only the synchronised value (rxs).
REQ-023 RX FSM states: IDLE, START, DATA, STOP.
REQ-024 IDLE: on a tick with rxs=0, enter START with the tick counter at 0.
REQ-025 START: at the 8th tick, if rxs=0, enter DATA; else (false start) return to IDLE.
REQ-026 DATA: sample rxs every 16 ticks (mid-bit) into a shift register, LSB first; after 8 samples enter STOP.
REQ-027 STOP: 16 ticks later, sample rxs.
REQ-028 STOP sample rxs=1: load acia_rx_data, set acia_rx_strobe=1 for exactly 4 clk, and return to IDLE.
REQ-029 STOP sample rxs=0: pulse frame_err for 1 clk with no strobe and no data update, then wait in IDLE until rxs=1 before re-arming.
REQ-030 acia_rx_data holds its value until the next good frame.
REQ-031 TX and RX are fully independent (full duplex); simultaneous activity must not alter either timing.
REQ-032 acia_tx_strobe and acia_rx_strobe never stay high longer than 4 clk.

Reset
REQ-033 Reset values: ikbd_txd=1, acia_tx_strobe=0, acia_rx_strobe=0, acia_rx_data=8'h00, frame_err=0, tx_busy=0; both FSMs IDLE; prescaler, bit and tick counters 0.
REQ-034 Reset mid-frame aborts immediately: ikbd_txd=1 on the next clk, a partial RX byte is discarded, and no strobe is issued.

Verification
REQ-035 acia_tx_available=1 with data 8'hA5 -> acia_tx_strobe high 4 clk; ikbd_txd then carries 0,1,0,1,0,0,1,0,1,1 at 1024 clk per bit; tx_busy=0 after the stop bit.
REQ-036 Drive ikbd_rxd with a frame for 8'h3C at 1024 clk/bit -> acia_rx_data=8'h3C and acia_rx_strobe high 4 clk, roughly 9.5 bits after the start edge.
REQ-037 Drive a 300-clk low glitch on ikbd_rxd -> no strobe, no frame_err, RX FSM back in IDLE.
REQ-038 Drive frame 8'hFF with stop bit 0 -> frame_err single pulse, acia_rx_data unchanged, no strobe; next valid frame 8'h12 received correctly.
REQ-039 Keep available=1 for three queued bytes 01,02,03 while receiving 8'h55 simultaneously -> three ACKs each 4 clk, three gap-4-clk frames, RX byte 8'h55 correct.
REQ-040 Assert reset during TX bit 4 and during RX bit 5 -> ikbd_txd=1 next clk, no strobes, all outputs at reset values.
